// File: rtl/io_core_multi.sv
// Parametrised IO core on the Manta bus: N_IN input / N_OUT output probes behind a
// 16-bit register window, with strobe-atomic sampling and sticky per-probe change flags.
module io_core_multi #(
    parameter logic [15:0]          BASE_ADDR = 16'd0,
    parameter int unsigned          N_IN      = 4,
    parameter int unsigned          IN_WIDTH  = 8,
    parameter int unsigned          N_OUT     = 2,
    parameter int unsigned          OUT_WIDTH = 8,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                addr_i,
    input  logic [15:0]                data_i,
    input  logic                       rw_i,
    input  logic                       valid_i,
    output logic [15:0]                addr_o,
    output logic [15:0]                data_o,
    output logic                       rw_o,
    output logic                       valid_o,
    input  logic [N_IN*IN_WIDTH-1:0]   probe_in,
    output logic [N_OUT*OUT_WIDTH-1:0] probe_out,
    output logic                       change_irq
);
    localparam int unsigned WI       = (IN_WIDTH + 15) / 16;
    localparam int unsigned WO       = (OUT_WIDTH + 15) / 16;
    localparam int unsigned IN_BASE  = 2;
    localparam int unsigned OUT_BASE = IN_BASE + N_IN * WI;
    localparam int unsigned WIN_SIZE = OUT_BASE + N_OUT * WO;
    localparam logic [OUT_WIDTH-1:0] WORD_MASK = OUT_WIDTH'(32'h0000_FFFF);

    logic [15:0] off;
    logic        in_win;
    logic        wr_en;
    logic        rd_en;
    logic        strobe;
    logic        chg_wr;

    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic        rw_q;
    logic        valid_q;
    logic [15:0] rd_word;

    logic [N_IN*IN_WIDTH-1:0]   in_q;
    logic [N_IN*IN_WIDTH-1:0]   in_q2;
    logic [N_IN*IN_WIDTH-1:0]   in_buf_q;
    logic [N_IN*IN_WIDTH-1:0]   in_buf_d;
    logic [N_OUT*OUT_WIDTH-1:0] out_buf_q;
    logic [N_OUT*OUT_WIDTH-1:0] out_buf_d;
    logic [N_OUT*OUT_WIDTH-1:0] probe_out_q;
    logic [N_OUT*OUT_WIDTH-1:0] probe_out_d;
    logic [N_IN-1:0]            change_q;
    logic [N_IN-1:0]            change_d;
    logic                       irq_q;

    // Offset wraps modulo 2^16, so addresses below BASE_ADDR land far outside the window.
    assign off    = addr_i - BASE_ADDR;
    assign in_win = ({16'd0, off} < WIN_SIZE);
    assign wr_en  = valid_i && rw_i && in_win;
    assign rd_en  = valid_i && !rw_i && in_win;
    assign strobe = wr_en && (off == 16'd0) && data_i[0];
    assign chg_wr = wr_en && (off == 16'd1);

    always_comb begin
        rd_word = '0;
        if (off == 16'd1) begin
            rd_word = 16'(change_q);
        end
        for (int unsigned p = 0; p < N_IN; p++) begin
            for (int unsigned w = 0; w < WI; w++) begin
                if (off == 16'(IN_BASE + p * WI + w)) begin
                    rd_word = 16'(in_buf_q[p*IN_WIDTH +: IN_WIDTH] >> (w * 16));
                end
            end
        end
        for (int unsigned p = 0; p < N_OUT; p++) begin
            for (int unsigned w = 0; w < WO; w++) begin
                if (off == 16'(OUT_BASE + p * WO + w)) begin
                    rd_word = 16'(out_buf_q[p*OUT_WIDTH +: OUT_WIDTH] >> (w * 16));
                end
            end
        end
    end

    always_comb begin
        out_buf_d = out_buf_q;
        for (int unsigned p = 0; p < N_OUT; p++) begin
            for (int unsigned w = 0; w < WO; w++) begin
                if (wr_en && (off == 16'(OUT_BASE + p * WO + w))) begin
                    out_buf_d[p*OUT_WIDTH +: OUT_WIDTH] =
                        (out_buf_q[p*OUT_WIDTH +: OUT_WIDTH] & ~(WORD_MASK << (w * 16)))
                        | (OUT_WIDTH'(data_i) << (w * 16));
                end
            end
        end
    end

    // Set is applied after clear so a coincident input change keeps the flag.
    always_comb begin
        change_d = change_q;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (chg_wr && data_i[k]) begin
                change_d[k] = 1'b0;
            end
            if (in_q[k*IN_WIDTH +: IN_WIDTH] != in_q2[k*IN_WIDTH +: IN_WIDTH]) begin
                change_d[k] = 1'b1;
            end
        end
    end

    always_comb begin
        in_buf_d    = strobe ? in_q : in_buf_q;
        probe_out_d = strobe ? out_buf_q : probe_out_q;
        data_d      = rd_en ? rd_word : data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            valid_q     <= 1'b0;
            in_q        <= '0;
            in_q2       <= '0;
            in_buf_q    <= '0;
            out_buf_q   <= {N_OUT{OUT_RESET}};
            probe_out_q <= {N_OUT{OUT_RESET}};
            change_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            addr_q      <= addr_i;
            data_q      <= data_d;
            rw_q        <= rw_i;
            valid_q     <= valid_i;
            in_q        <= probe_in;
            in_q2       <= in_q;
            in_buf_q    <= in_buf_d;
            out_buf_q   <= out_buf_d;
            probe_out_q <= probe_out_d;
            change_q    <= change_d;
            irq_q       <= |change_q;
        end
    end

    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign rw_o       = rw_q;
    assign valid_o    = valid_q;
    assign probe_out  = probe_out_q;
    assign change_irq = irq_q;

endmodule

// File: tb/tb_io_core_multi.sv
// Two io_core_multi instances (narrow probes and 40-bit probes) share one bus; every
// output is compared each cycle against a register-map reference model.
module tb_io_core_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic        rw_in;
    logic        valid_in;

    logic [31:0] a_pin;
    logic [15:0] a_pout;
    logic [15:0] a_addr_o;
    logic [15:0] a_data_o;
    logic        a_rw_o;
    logic        a_valid_o;
    logic        a_irq;

    logic [79:0] b_pin;
    logic [19:0] b_pout;
    logic [15:0] b_addr_o;
    logic [15:0] b_data_o;
    logic        b_rw_o;
    logic        b_valid_o;
    logic        b_irq;

    io_core_multi #(
        .BASE_ADDR(16'h0040), .N_IN(4), .IN_WIDTH(8),
        .N_OUT(2), .OUT_WIDTH(8), .OUT_RESET(8'hA5)
    ) u_a (
        .clk(clk), .rst(rst),
        .addr_i(addr_in), .data_i(data_in), .rw_i(rw_in), .valid_i(valid_in),
        .addr_o(a_addr_o), .data_o(a_data_o), .rw_o(a_rw_o), .valid_o(a_valid_o),
        .probe_in(a_pin), .probe_out(a_pout), .change_irq(a_irq)
    );

    io_core_multi #(
        .BASE_ADDR(16'h0200), .N_IN(2), .IN_WIDTH(40),
        .N_OUT(1), .OUT_WIDTH(20), .OUT_RESET(20'h5A5A5)
    ) u_b (
        .clk(clk), .rst(rst),
        .addr_i(addr_in), .data_i(data_in), .rw_i(rw_in), .valid_i(valid_in),
        .addr_o(b_addr_o), .data_o(b_data_o), .rw_o(b_rw_o), .valid_o(b_valid_o),
        .probe_in(b_pin), .probe_out(b_pout), .change_irq(b_irq)
    );

    int unsigned c_base [2] = '{32'h0040, 32'h0200};
    int unsigned c_nin  [2] = '{4, 2};
    int unsigned c_inw  [2] = '{8, 40};
    int unsigned c_nout [2] = '{2, 1};
    int unsigned c_outw [2] = '{8, 20};
    logic [63:0] c_orst [2] = '{64'hA5, 64'h5A5A5};

    logic [63:0] m_pin    [2][16];
    logic [63:0] m_inq    [2][16];
    logic [63:0] m_inq2   [2][16];
    logic [63:0] m_inbuf  [2][16];
    logic [63:0] m_outbuf [2][16];
    logic [63:0] m_pout   [2][16];
    logic [15:0] m_chg    [2];
    logic        m_irq    [2];
    logic [15:0] m_data   [2];
    logic [15:0] m_addr;
    logic        m_rw;
    logic        m_valid;

    int vectors = 0;
    int errors  = 0;

    function automatic logic [63:0] wmask(input int unsigned w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [15:0] m_read(input int i, input int unsigned off);
        int unsigned wi, wo, ib, ob, j;
        wi = (c_inw[i] + 15) / 16;
        wo = (c_outw[i] + 15) / 16;
        ib = 2 + c_nin[i] * wi;
        ob = ib + c_nout[i] * wo;
        if (off == 1) return m_chg[i];
        if (off >= 2 && off < ib) begin
            j = off - 2;
            return 16'(m_inbuf[i][j / wi] >> (16 * (j % wi)));
        end
        if (off >= ib && off < ob) begin
            j = off - ib;
            return 16'(m_outbuf[i][j / wo] >> (16 * (j % wo)));
        end
        return 16'h0000;
    endfunction

    task automatic model_step();
        int unsigned off, wi, wo, ob, j, p, sh;
        logic [15:0] off16, rdv, chg_new;
        logic        inwin, wr, rd;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) begin
                    m_inq[i][k]    = '0;
                    m_inq2[i][k]   = '0;
                    m_inbuf[i][k]  = '0;
                    m_outbuf[i][k] = c_orst[i];
                    m_pout[i][k]   = c_orst[i];
                end
                m_chg[i]  = '0;
                m_irq[i]  = 1'b0;
                m_data[i] = '0;
            end else begin
                wi    = (c_inw[i] + 15) / 16;
                wo    = (c_outw[i] + 15) / 16;
                ob    = 2 + c_nin[i] * wi;
                off16 = addr_in - 16'(c_base[i]);
                off   = 32'(off16);
                inwin = (off < ob + c_nout[i] * wo);
                wr    = valid_in && rw_in && inwin;
                rd    = valid_in && !rw_in && inwin;
                rdv   = m_read(i, off);
                chg_new = m_chg[i];
                if (wr && off == 1) chg_new = chg_new & ~data_in;
                for (int k = 0; k < int'(c_nin[i]); k++)
                    if (m_inq[i][k] != m_inq2[i][k]) chg_new[k] = 1'b1;
                m_irq[i] = |m_chg[i];
                m_chg[i] = chg_new;
                if (wr && off == 0 && data_in[0]) begin
                    for (int k = 0; k < 16; k++) begin
                        m_inbuf[i][k] = m_inq[i][k];
                        m_pout[i][k]  = m_outbuf[i][k];
                    end
                end
                if (wr && off >= ob) begin
                    j  = off - ob;
                    p  = j / wo;
                    sh = 16 * (j % wo);
                    m_outbuf[i][p] = ((m_outbuf[i][p] & ~(64'hFFFF << sh))
                                      | (64'(data_in) << sh)) & wmask(c_outw[i]);
                end
                m_data[i] = rd ? rdv : data_in;
                for (int k = 0; k < 16; k++) begin
                    m_inq2[i][k] = m_inq[i][k];
                    m_inq[i][k]  = m_pin[i][k] & wmask(c_inw[i]);
                end
            end
        end
        m_addr  = rst ? 16'h0000 : addr_in;
        m_rw    = rst ? 1'b0 : rw_in;
        m_valid = rst ? 1'b0 : valid_in;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] pa;
        for (int k = 0; k < 2; k++) pa[k*8 +: 8] = m_pout[0][k][7:0];
        check("A.valid_o", 64'(a_valid_o), 64'(m_valid));
        check("A.rw_o",    64'(a_rw_o),    64'(m_rw));
        check("A.addr_o",  64'(a_addr_o),  64'(m_addr));
        check("A.data_o",  64'(a_data_o),  64'(m_data[0]));
        check("A.probe_out", 64'(a_pout),  64'(pa));
        check("A.irq",     64'(a_irq),     64'(m_irq[0]));
        check("B.valid_o", 64'(b_valid_o), 64'(m_valid));
        check("B.rw_o",    64'(b_rw_o),    64'(m_rw));
        check("B.addr_o",  64'(b_addr_o),  64'(m_addr));
        check("B.data_o",  64'(b_data_o),  64'(m_data[1]));
        check("B.probe_out", 64'(b_pout),  64'(m_pout[1][0][19:0]));
        check("B.irq",     64'(b_irq),     64'(m_irq[1]));
    endtask

    task automatic cycle();
        for (int k = 0; k < 4; k++) a_pin[k*8 +: 8]   = m_pin[0][k][7:0];
        for (int k = 0; k < 2; k++) b_pin[k*40 +: 40] = m_pin[1][k][39:0];
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic rw);
        addr_in  = a;
        data_in  = d;
        rw_in    = rw;
        valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            valid_in = 1'b0;
            cycle();
        end
    endtask

    task automatic rd(input int i, input logic [15:0] a, input logic [15:0] exp, input string tag);
        bus(a, 16'hDEAD, 1'b0);
        check(tag, 64'((i == 0) ? a_data_o : b_data_o), 64'(exp));
    endtask

    initial begin
        logic [15:0] pa;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++) m_pin[i][k] = '0;

        // Reset with a write in flight; it must not commit.
        rst = 1'b1; addr_in = 16'h0046; data_in = 16'h1234; rw_in = 1'b1; valid_in = 1'b1;
        cycle();
        cycle();
        check("rst.a_pout",  64'(a_pout),    64'(16'hA5A5));
        check("rst.b_pout",  64'(b_pout),    64'(20'h5A5A5));
        check("rst.valid_o", 64'(a_valid_o), 64'(1'b0));
        check("rst.irq",     64'(a_irq),     64'(1'b0));
        rst = 1'b0; valid_in = 1'b0;
        rd(0, 16'h0041, 16'h0000, "rst.change");

        // Output staging
        bus(16'h0046, 16'hFF3C, 1'b1);
        check("stage.hold", 64'(a_pout), 64'(16'hA5A5));
        bus(16'h0040, 16'h0001, 1'b1);
        check("stage.strobe", 64'(a_pout), 64'(16'hA53C));
        rd(0, 16'h0046, 16'h003C, "stage.readback");

        // Input snapshot
        m_pin[0][0] = 64'h44; m_pin[0][1] = 64'h33; m_pin[0][2] = 64'h22; m_pin[0][3] = 64'h11;
        idle(1);
        bus(16'h0040, 16'h0001, 1'b1);
        for (int k = 0; k < 4; k++) m_pin[0][k] = '0;
        idle(2);
        rd(0, 16'h0042, 16'h0044, "snap.w0");
        rd(0, 16'h0043, 16'h0033, "snap.w1");
        rd(0, 16'h0044, 16'h0022, "snap.w2");
        rd(0, 16'h0045, 16'h0011, "snap.w3");
        bus(16'h0040, 16'hFFFE, 1'b1);
        rd(0, 16'h0042, 16'h0044, "snap.nostrobe");

        // Change flags
        idle(2);
        bus(16'h0041, 16'h000F, 1'b1);
        rd(0, 16'h0041, 16'h0000, "chg.cleared");
        m_pin[0][2] = m_pin[0][2] ^ 64'h1;
        idle(2);
        check("chg.irq_early", 64'(a_irq), 64'(1'b0));
        idle(1);
        check("chg.irq_set", 64'(a_irq), 64'(1'b1));
        rd(0, 16'h0041, 16'h0004, "chg.flag");
        bus(16'h0041, 16'h0004, 1'b1);
        check("chg.irq_hold", 64'(a_irq), 64'(1'b1));
        idle(1);
        check("chg.irq_fall", 64'(a_irq), 64'(1'b0));
        rd(0, 16'h0041, 16'h0000, "chg.clear");
        m_pin[0][2] = m_pin[0][2] ^ 64'h1;
        idle(1);
        bus(16'h0041, 16'h0004, 1'b1);
        rd(0, 16'h0041, 16'h0004, "chg.setwins");

        // Passthrough
        bus(16'h00A4, 16'hBEEF, 1'b0);
        check("pass.addr",  64'(a_addr_o),  64'(16'h00A4));
        check("pass.data",  64'(a_data_o),  64'(16'hBEEF));
        check("pass.rw",    64'(a_rw_o),    64'(1'b0));
        check("pass.valid", 64'(a_valid_o), 64'(1'b1));
        for (int n = 0; n < 8; n++) begin
            pa = 16'($urandom);
            bus(pa, 16'($urandom), 1'($urandom_range(0, 1)));
            check("stream.addr",  64'(b_addr_o),  64'(pa));
            check("stream.valid", 64'(b_valid_o), 64'(1'b1));
        end

        // Wide probes
        m_pin[1][0] = 64'hAB_CDEF_1234;
        m_pin[1][1] = 64'h12_3456_789A;
        idle(1);
        bus(16'h0200, 16'h0001, 1'b1);
        rd(1, 16'h0202, 16'h1234, "wide.p0w0");
        rd(1, 16'h0203, 16'hCDEF, "wide.p0w1");
        rd(1, 16'h0204, 16'h00AB, "wide.p0w2");
        rd(1, 16'h0205, 16'h789A, "wide.p1w0");
        rd(1, 16'h0206, 16'h3456, "wide.p1w1");
        rd(1, 16'h0207, 16'h0012, "wide.p1w2");
        bus(16'h0208, 16'h1111, 1'b1);
        bus(16'h0209, 16'hFFFF, 1'b1);
        rd(1, 16'h0209, 16'h000F, "wide.outhi");
        rd(1, 16'h020A, 16'hDEAD, "wide.oor");
        bus(16'h0200, 16'h0001, 1'b1);
        check("wide.pout", 64'(b_pout), 64'(20'hF1111));

        // Reset coinciding with a strobe
        bus(16'h0047, 16'h0077, 1'b1);
        rst = 1'b1;
        bus(16'h0040, 16'h0001, 1'b1);
        check("mrst.a_pout", 64'(a_pout), 64'(16'hA5A5));
        rst = 1'b0;
        rd(0, 16'h0047, 16'h00A5, "mrst.outbuf");

        // Random traffic across both windows and outside them
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 16; k++)
                    if ($urandom_range(0, 7) == 0)
                        m_pin[i][k] = {$urandom(), $urandom()} & wmask(c_inw[i]);
            valid_in = ($urandom_range(0, 3) != 0);
            rw_in    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0, 1:    addr_in = 16'h0040 + 16'($urandom_range(0, 9));
                2, 3:    addr_in = 16'h0200 + 16'($urandom_range(0, 11));
                default: addr_in = 16'($urandom);
            endcase
            data_in = 16'($urandom);
            cycle();
        end
        rst = 1'b0;
        valid_in = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
